// File: rtl/prach_pkg.sv
// prach_pkg: shared types and constants for the PRACH Avalon-ST packer.
//   NUM_ANT / NUM_CC / SAMPLE_W / WORD_W : stream geometry
//   fifo_entry_t : one FIFO entry = three 128-bit words (one per CC) + tag
//   ser_state_t  : output serialiser state
//   chan_id()    : Avalon channel number {cc, ant}
package prach_pkg;

  localparam int NUM_ANT  = 8;
  localparam int NUM_CC   = 3;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 128;

  typedef struct packed {
    logic [NUM_CC-1:0][WORD_W-1:0] data;
    logic [2:0]                    ant;
    logic                          sop;
    logic                          eop;
  } fifo_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Channel field: carrier in the upper byte, antenna in the lower byte.
  function automatic logic [15:0] chan_id(input logic [1:0] cc, input logic [2:0] ant);
    return {6'd0, cc, 5'd0, ant};
  endfunction

endpackage

// File: rtl/prach_packer_fifo.sv
// prach_packer_fifo: single-clock show-ahead FIFO of fifo_entry_t.
//   clk, rst          : clock, synchronous active-high reset (pointers only)
//   wr_en, wr_data    : write request; ignored while full
//   rd_en, rd_data    : rd_data always shows the head; rd_en pops it
//   full, empty       : occupancy flags, valid before this cycle's write/read
module prach_packer_fifo
  import prach_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written only when there is room.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/prach_packer.sv
// prach_packer: packs per-(antenna, CC) PRACH IQ samples, four per 128-bit
// word, buffers them per antenna in a FIFO and serialises CC0..CC2 words onto
// an Avalon-ST source with channel, SOP/EOP and ready backpressure.
//   clk, rst              : DSP clock, synchronous active-high reset
//   din_dr/din_di/din_dv  : per-CC I/Q sample beat, din_chn = antenna (>=8 ignored)
//   sync_in               : occasion start; restarts all sample/word counters
//   avst_source_*         : Avalon-ST source, ready latency 0
//   stat_overflow         : sticky, set when a completed entry is dropped
//   stat_drop_cnt         : dropped entries, saturating
module prach_packer
  import prach_pkg::*;
#(
  parameter int PKT_WORDS  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CC-1:0][SAMPLE_W-1:0] din_dr,
  input  logic [NUM_CC-1:0][SAMPLE_W-1:0] din_di,
  input  logic                            din_dv,
  input  logic [7:0]                      din_chn,
  input  logic                            sync_in,
  output logic [WORD_W-1:0]               avst_source_data,
  output logic                            avst_source_valid,
  output logic [15:0]                     avst_source_channel,
  output logic                            avst_source_startofpacket,
  output logic                            avst_source_endofpacket,
  input  logic                            avst_source_ready,
  output logic                            stat_overflow,
  output logic [15:0]                     stat_drop_cnt
);

  localparam logic [7:0] LAST_WORD = 8'(PKT_WORDS - 1);

  logic [1:0] scnt [NUM_ANT];
  logic [7:0] wcnt [NUM_ANT];
  // Three buffered samples per (antenna, CC); slot 0 is the earliest.
  logic [NUM_CC-1:0][2:0][2*SAMPLE_W-1:0] partial [NUM_ANT];

  logic        accept;
  logic        complete;
  logic [2:0]  ant;
  logic [1:0]  scnt_cur;
  logic [7:0]  wcnt_cur;
  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  ser_state_t               state;
  logic [1:0]               cc;
  logic [1:0][WORD_W-1:0]   rest;     // CC1 and CC2 words of the entry being sent
  logic [2:0]               cur_ant;

  assign accept   = din_dv && (din_chn < 8'd8);
  assign ant      = din_chn[2:0];
  assign complete = accept && (scnt_cur == 2'd3);

  // Counters as seen by this beat; a sync in the same cycle makes it sample 0.
  always_comb begin
    scnt_cur = 2'd0;
    wcnt_cur = 8'd0;
    if (sync_in) begin
      scnt_cur = 2'd0;
      wcnt_cur = 8'd0;
    end else begin
      scnt_cur = scnt[ant];
      wcnt_cur = wcnt[ant];
    end
  end

  // Completed entry: the current sample becomes s3 on top of the buffered ones.
  always_comb begin
    wr_entry = '0;
    for (int c = 0; c < NUM_CC; c++) begin
      wr_entry.data[c] = {din_di[c], din_dr[c],
                          partial[ant][c][2], partial[ant][c][1], partial[ant][c][0]};
    end
    wr_entry.ant = ant;
    wr_entry.sop = (wcnt_cur == 8'd0);
    wr_entry.eop = (wcnt_cur == LAST_WORD);
  end

  // Input side: sample/word counters, partial words and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_ANT; a++) begin
        scnt[a]    <= 2'd0;
        wcnt[a]    <= 8'd0;
        partial[a] <= '0;
      end
      stat_overflow <= 1'b0;
      stat_drop_cnt <= 16'd0;
    end else begin
      if (sync_in) begin
        for (int a = 0; a < NUM_ANT; a++) begin
          scnt[a] <= 2'd0;
          wcnt[a] <= 8'd0;
        end
      end
      if (accept) begin
        scnt[ant] <= scnt_cur + 2'd1;
        if (complete) begin
          // Word counter advances even if the entry is dropped below.
          wcnt[ant] <= (wcnt_cur == LAST_WORD) ? 8'd0 : wcnt_cur + 8'd1;
        end else begin
          for (int c = 0; c < NUM_CC; c++) begin
            partial[ant][c][scnt_cur] <= {din_di[c], din_dr[c]};
          end
        end
      end
      if (complete && fifo_full) begin
        stat_overflow <= 1'b1;
        if (stat_drop_cnt != 16'hFFFF) begin
          stat_drop_cnt <= stat_drop_cnt + 16'd1;
        end
      end
    end
  end

  prach_packer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (complete),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pop when idle, or when the CC2 word transfers, so entries chain without a bubble.
  always_comb begin
    pop = 1'b0;
    if (fifo_empty) begin
      pop = 1'b0;
    end else if (state == ST_IDLE) begin
      pop = 1'b1;
    end else if (avst_source_valid && avst_source_ready && (cc == 2'd2)) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // Output serialiser: registered Avalon-ST outputs, held while ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= ST_IDLE;
      cc                        <= 2'd0;
      rest                      <= '0;
      cur_ant                   <= 3'd0;
      avst_source_valid         <= 1'b0;
      avst_source_data          <= '0;
      avst_source_channel       <= 16'd0;
      avst_source_startofpacket <= 1'b0;
      avst_source_endofpacket   <= 1'b0;
    end else if (pop) begin
      state                     <= ST_SEND;
      cc                        <= 2'd0;
      rest                      <= {head.data[2], head.data[1]};
      cur_ant                   <= head.ant;
      avst_source_valid         <= 1'b1;
      avst_source_data          <= head.data[0];
      avst_source_channel       <= chan_id(2'd0, head.ant);
      avst_source_startofpacket <= head.sop;
      avst_source_endofpacket   <= head.eop;
    end else begin
      case (state)
        ST_IDLE: begin
          avst_source_valid <= 1'b0;
        end
        ST_SEND: begin
          if (avst_source_valid && avst_source_ready) begin
            if (cc != 2'd2) begin
              cc                  <= cc + 2'd1;
              avst_source_data    <= rest[cc[0]];
              avst_source_channel <= chan_id(cc + 2'd1, cur_ant);
            end else begin
              avst_source_valid <= 1'b0;
              state             <= ST_IDLE;
            end
          end
        end
        default: begin
          avst_source_valid <= 1'b0;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prach_packer.sv
// tb_prach_packer: directed stimulus with a scoreboard for prach_packer.
// Expected words are pushed when the bench's own model accepts an entry into
// its FIFO image and compared on every cycle the DUT presents valid data.
module tb_prach_packer;

  localparam int PKT_WORDS  = 16;
  localparam int FIFO_DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][15:0] din_dr;
  logic [2:0][15:0] din_di;
  logic             din_dv;
  logic [7:0]       din_chn;
  logic             sync_in;
  logic [127:0]     avst_source_data;
  logic             avst_source_valid;
  logic [15:0]      avst_source_channel;
  logic             avst_source_startofpacket;
  logic             avst_source_endofpacket;
  logic             avst_source_ready;
  logic             stat_overflow;
  logic [15:0]      stat_drop_cnt;

  prach_packer #(
    .PKT_WORDS  (PKT_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .din_dr                    (din_dr),
    .din_di                    (din_di),
    .din_dv                    (din_dv),
    .din_chn                   (din_chn),
    .sync_in                   (sync_in),
    .avst_source_data          (avst_source_data),
    .avst_source_valid         (avst_source_valid),
    .avst_source_channel       (avst_source_channel),
    .avst_source_startofpacket (avst_source_startofpacket),
    .avst_source_endofpacket   (avst_source_endofpacket),
    .avst_source_ready         (avst_source_ready),
    .stat_overflow             (stat_overflow),
    .stat_drop_cnt             (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  chan;
    logic         sop;
    logic         eop;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           m_scnt [8];
  int           m_wcnt [8];
  logic [95:0]  m_part [8][3];
  int           m_cnt = 0;
  logic         m_valid = 1'b0;
  int           m_cc = 0;
  int           m_drops = 0;
  int           dut_words = 0;
  logic         obs_valid = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Bench model of one clock edge, using the inputs the DUT samples at it.
  task automatic model_edge();
    logic xfer;
    logic pop;
    int   a;
    int   s;
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_scnt[k] = 0;
        m_wcnt[k] = 0;
      end
      exp_q.delete();
      m_cnt = 0; m_valid = 1'b0; m_cc = 0; m_drops = 0;
      return;
    end
    if (obs_valid && avst_source_ready) dut_words++;
    xfer = m_valid && avst_source_ready;
    if (xfer && exp_q.size() != 0) void'(exp_q.pop_front());
    pop = 1'b0;
    if (!m_valid) pop = (m_cnt > 0);
    else if (xfer && m_cc == 2) pop = (m_cnt > 0);
    if (pop) begin
      m_valid = 1'b1; m_cc = 0;
    end else if (xfer) begin
      if (m_cc == 2) m_valid = 1'b0;
      else m_cc++;
    end
    if (sync_in) begin
      for (int k = 0; k < 8; k++) begin
        m_scnt[k] = 0;
        m_wcnt[k] = 0;
      end
    end
    if (din_dv && din_chn < 8'd8) begin
      a = int'(din_chn);
      s = m_scnt[a];
      if (s == 3) begin
        if (m_cnt == FIFO_DEPTH) begin
          m_drops++;
        end else begin
          m_cnt++;
          for (int c = 0; c < 3; c++) begin
            e.data = {din_di[c], din_dr[c], m_part[a][c]};
            e.chan = {8'(c), 8'(a)};
            e.sop  = (m_wcnt[a] == 0);
            e.eop  = (m_wcnt[a] == PKT_WORDS - 1);
            exp_q.push_back(e);
          end
        end
        m_wcnt[a] = (m_wcnt[a] == PKT_WORDS - 1) ? 0 : m_wcnt[a] + 1;
      end else begin
        for (int c = 0; c < 3; c++) m_part[a][c][s*32 +: 32] = {din_di[c], din_dr[c]};
      end
      m_scnt[a] = (s + 1) % 4;
    end
    if (pop) m_cnt--;
  endtask

  task automatic check_outputs();
    obs_valid = avst_source_valid;
    chk("valid", 128'(avst_source_valid), 128'(m_valid));
    if (m_valid) begin
      chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        chk("data", avst_source_data, exp_q[0].data);
        chk("channel", 128'(avst_source_channel), 128'(exp_q[0].chan));
        chk("sop", 128'(avst_source_startofpacket), 128'(exp_q[0].sop));
        chk("eop", 128'(avst_source_endofpacket), 128'(exp_q[0].eop));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    din_dv  = 1'b0;
    sync_in = 1'b0;
    step();
  endtask

  task automatic beat(input logic [7:0] chn, input logic [15:0] r, input logic [15:0] i,
                      input logic sync, input logic [15:0] ccoff);
    din_dv  = 1'b1;
    din_chn = chn;
    sync_in = sync;
    for (int c = 0; c < 3; c++) begin
      din_dr[c] = r + 16'(c) * ccoff;
      din_di[c] = i + 16'(c) * ccoff;
    end
    step();
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic sync_pulse();
    din_dv  = 1'b0;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    avst_source_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      idle();
      n++;
    end
    chk("drain_done", 128'(exp_q.size() == 0 && !m_valid), 128'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!avst_source_valid && n < 8) begin
      idle();
      n++;
    end
    chk(tag, 128'(avst_source_valid), 128'd1);
  endtask

  initial begin
    int w0;
    rst = 1'b1; din_dv = 1'b0; din_chn = 8'd0; sync_in = 1'b0;
    din_dr = '0; din_di = '0; avst_source_ready = 1'b1;

    // Reset values
    step();
    chk("rst_data", avst_source_data, 128'd0);
    chk("rst_channel", 128'(avst_source_channel), 128'd0);
    chk("rst_sop", 128'(avst_source_startofpacket), 128'd0);
    chk("rst_eop", 128'(avst_source_endofpacket), 128'd0);
    chk("rst_overflow", 128'(stat_overflow), 128'd0);
    chk("rst_drop_cnt", 128'(stat_drop_cnt), 128'd0);
    step();
    rst = 1'b0;
    idle();

    // Antenna 2 only, dr=k, di=-k: one packet per CC
    w0 = dut_words;
    avst_source_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(8'd2, 16'(k), 16'(-k), 1'b0, 16'd0);
    wait_valid("t1_first_valid");
    chk("t1_first_data", avst_source_data,
        {16'hFFFD, 16'h0003, 16'hFFFE, 16'h0002, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000});
    chk("t1_first_chan", 128'(avst_source_channel), 128'h0002);
    chk("t1_first_sop", 128'(avst_source_startofpacket), 128'd1);
    avst_source_ready = 1'b1;
    for (int k = 4; k < 64; k++) beat(8'd2, 16'(k), 16'(-k), 1'b0, 16'd0);
    drain();
    chk("t1_words", 128'(dut_words - w0), 128'd48);

    // Sync after two samples on antenna 0 discards them
    sync_pulse();
    avst_source_ready = 1'b0;
    beat(8'd0, 16'h0111, 16'h0222, 1'b0, 16'h0100);
    beat(8'd0, 16'h0333, 16'h0444, 1'b0, 16'h0100);
    beat(8'd0, 16'h0AAA, 16'h0BBB, 1'b1, 16'h0100);
    for (int k = 0; k < 3; k++) beat(8'd0, 16'(k + 16'h0050), 16'(k + 16'h0060), 1'b0, 16'h0100);
    wait_valid("t4_valid");
    chk("t4_s0", 128'(avst_source_data[31:0]), 128'h0BBB0AAA);
    chk("t4_sop", 128'(avst_source_startofpacket), 128'd1);
    drain();

    // Out-of-range antenna beats interleaved with antenna 1 traffic
    sync_pulse();
    w0 = dut_words;
    for (int k = 0; k < 16; k++) begin
      beat(8'd1, 16'(k), 16'(k + 100), 1'b0, 16'h0010);
      beat(8'd9, 16'hDEAD, 16'hBEEF, 1'b0, 16'h0001);
    end
    drain();
    chk("t5_words", 128'(dut_words - w0), 128'd12);

    // Full-rate round robin, ready always high
    sync_pulse();
    w0 = dut_words;
    for (int k = 0; k < 512; k++) beat(8'(k % 8), 16'(k * 7), 16'(k * 13 + 5), 1'b0, 16'h0100);
    drain();
    chk("t2_words", 128'(dut_words - w0), 128'd384);
    chk("t2_drop_cnt", 128'(stat_drop_cnt), 128'd0);
    chk("t2_overflow", 128'(stat_overflow), 128'd0);

    // Full-rate input with 50% ready
    sync_pulse();
    w0 = dut_words;
    for (int k = 0; k < 512; k++) begin
      avst_source_ready = (k % 2 == 0);
      beat(8'(k % 8), 16'(k * 3 + 1), 16'(k * 5 + 2), 1'b0, 16'h0200);
    end
    drain();
    chk("t3_overflow", 128'(stat_overflow), 128'd1);
    chk("t3_drop_cnt", 128'(stat_drop_cnt), 128'(m_drops));
    chk("t3_words", 128'(dut_words - w0), 128'(3 * (128 - int'(stat_drop_cnt))));

    // Reset while sending CC1 of an entry with another entry queued
    sync_pulse();
    avst_source_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(8'd3, 16'(k + 16'h0300), 16'(k + 16'h0400), 1'b0, 16'h0010);
    avst_source_ready = 1'b1;
    idle();
    chk("t6_cc1_chan", 128'(avst_source_channel), 128'h0103);
    rst = 1'b1;
    idle();
    chk("t6_valid_after_rst", 128'(avst_source_valid), 128'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) idle();
    chk("t6_overflow", 128'(stat_overflow), 128'd0);
    chk("t6_drop_cnt", 128'(stat_drop_cnt), 128'd0);
    avst_source_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(8'd5, 16'(k + 16'h0500), 16'(k + 16'h0600), 1'b0, 16'h0010);
    wait_valid("t6_new_valid");
    chk("t6_new_sop", 128'(avst_source_startofpacket), 128'd1);
    chk("t6_new_chan", 128'(avst_source_channel), 128'h0005);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
